// File: rtl/sram_bist_pkg.sv
// Shared types, the March C- element table and small lookups for the
// SRAM March BIST sequencer.
//   state_e     : sequencer states (IDLE, RUN, DRAIN, DONE)
//   elem_e      : march element index M0..M5
//   elem_attr_t : per-element direction, read/write polarity and op flags
//   ELEM_TBL    : constant attribute table indexed by elem_e
//   depth_of()  : word count of the macro selected by sel
//   cen_for()   : active-low chip-enable vector for the selected macro
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  // up: ascending addresses; rd_inv: read expects ~P; wr_inv: write ~P
  typedef struct packed {
    logic up;
    logic rd_inv;
    logic wr_inv;
    logic has_rd;
    logic has_wr;
  } elem_attr_t;

  // Entries 6 and 7 are never reached; they keep the index fully decoded.
  localparam elem_attr_t ELEM_TBL [8] = '{
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1},  // M0 up   : w P
    '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},  // M1 up   : r P,  w ~P
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},  // M2 up   : r ~P, w P
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},  // M3 down : r P,  w ~P
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},  // M4 down : r ~P, w P
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // M5 down : r P
    elem_attr_t'(5'b00000),
    elem_attr_t'(5'b00000)
  };

  function automatic logic [31:0] depth_of(input logic [1:0] sel,
                                           input int d0, input int d1,
                                           input int d2, input int d3);
    case (sel)
      2'd0:    depth_of = 32'(d0);
      2'd1:    depth_of = 32'(d1);
      2'd2:    depth_of = 32'(d2);
      default: depth_of = 32'(d3);
    endcase
  endfunction

  function automatic logic [3:0] cen_for(input logic [1:0] sel);
    case (sel)
      2'd0:    cen_for = 4'b1110;
      2'd1:    cen_for = 4'b1101;
      2'd2:    cen_for = 4'b1011;
      default: cen_for = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march sequencer.
//   clk_i, rst_i : clock, async active-high reset (counter -> 0)
//   load_i       : load the start address for direction load_up_i
//   load_up_i    : direction of the element being loaded (0 or last_i)
//   step_i       : advance one address in direction up_i
//   up_i         : direction of the element currently running
//   last_i       : highest address of the selected macro (N-1)
//   addr_o       : current address (registered)
//   tc_o         : current address is the last one for direction up_i
module sram_bist_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          load_up_i,
  input  logic          step_i,
  input  logic          up_i,
  input  logic [AW-1:0] last_i,
  output logic [AW-1:0] addr_o,
  output logic          tc_o
);

  logic [AW-1:0] addr_q, addr_d;

  // Next address: load has priority over step.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_up_i ? {AW{1'b0}} : last_i;
    end else if (step_i) begin
      addr_d = up_i ? (addr_q + AW'(1)) : (addr_q - AW'(1));
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= {AW{1'b0}};
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = up_i ? (addr_q == last_i) : (addr_q == {AW{1'b0}});

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for one of four single-port SRAM macros.
// Every bus output is a register holding the access that executes at the
// next rising edge. Read data is compared one edge after the read executes.
//   CLK, RST    : clock, async active-high reset
//   start       : begin a run (sampled in IDLE only) with sel, pattern
//   Q           : read data from the selected macro
//   CEN/GWEN/WEN/A/D : shared SRAM bus (active-low enables)
//   busy, done  : run in progress / run complete (held until next start)
//   fail, fail_addr, fail_elem, fail_bits : sticky flag + first mismatch
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int DEPTH0 = 1024,
  parameter int DEPTH1 = 512,
  parameter int DEPTH2 = 256,
  parameter int DEPTH3 = 256
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] pattern,
  input  logic [DW-1:0] Q,
  output logic [3:0]    CEN,
  output logic          GWEN,
  output logic [DW-1:0] WEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [DW-1:0] fail_bits
);

  state_e        state_q, state_d;
  elem_e         elem_q, elem_d;
  logic          wr_phase_q, wr_phase_d;  // bus currently carries the write op
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] pat_q, pat_d;
  logic [AW-1:0] last_q, last_d;

  logic [3:0]    cen_q, cen_d;
  logic          gwen_q, gwen_d;
  logic [DW-1:0] wen_q, wen_d;
  logic [DW-1:0] d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Compare stage: the read that executed at the previous edge.
  logic          rd1_q, rd1_d;
  logic [DW-1:0] exp1_q, exp1_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [2:0]    elem1_q, elem1_d;

  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;
  logic [DW-1:0] fail_bits_q, fail_bits_d;

  logic          load_s, load_up_s, step_s, tc_s;
  logic [AW-1:0] addr_s;
  elem_attr_t    attr_cur_s;
  elem_e         elem_nxt_s;

  assign attr_cur_s = ELEM_TBL[elem_q];
  assign elem_nxt_s = elem_e'(elem_q + 3'd1);

  sram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load_s),
    .load_up_i (load_up_s),
    .step_i    (step_s),
    .up_i      (attr_cur_s.up),
    .last_i    (last_q),
    .addr_o    (addr_s),
    .tc_o      (tc_s)
  );

  // Sequencer next state and the next bus access.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    wr_phase_d = wr_phase_q;
    sel_d      = sel_q;
    pat_d      = pat_q;
    last_d     = last_q;
    cen_d      = 4'hF;
    gwen_d     = 1'b1;
    wen_d      = {DW{1'b1}};
    d_d        = d_q;
    busy_d     = busy_q;
    done_d     = done_q;
    load_s     = 1'b0;
    load_up_s  = 1'b1;
    step_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // First access (M0 w P at address 0) goes out with the accept.
          sel_d      = sel;
          pat_d      = pattern;
          last_d     = AW'(depth_of(sel, DEPTH0, DEPTH1, DEPTH2, DEPTH3) - 32'd1);
          elem_d     = M0;
          wr_phase_d = 1'b1;
          load_s     = 1'b1;
          load_up_s  = 1'b1;
          cen_d      = cen_for(sel);
          gwen_d     = 1'b0;
          wen_d      = {DW{1'b0}};
          d_d        = pattern;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!wr_phase_q && attr_cur_s.has_wr) begin
          // Second half of r+w: write at the same address.
          wr_phase_d = 1'b1;
          cen_d      = cen_for(sel_q);
          gwen_d     = 1'b0;
          wen_d      = {DW{1'b0}};
          d_d        = attr_cur_s.wr_inv ? ~pat_q : pat_q;
        end else if (tc_s) begin
          if (elem_q == M5) begin
            state_d = ST_DRAIN;
          end else begin
            // Element change: reload start address for the new direction.
            elem_d     = elem_nxt_s;
            load_s     = 1'b1;
            load_up_s  = ELEM_TBL[elem_nxt_s].up;
            wr_phase_d = ~ELEM_TBL[elem_nxt_s].has_rd;
            cen_d      = cen_for(sel_q);
            if (ELEM_TBL[elem_nxt_s].has_rd) begin
              gwen_d = 1'b1;
              wen_d  = {DW{1'b1}};
            end else begin
              gwen_d = 1'b0;
              wen_d  = {DW{1'b0}};
              d_d    = ELEM_TBL[elem_nxt_s].wr_inv ? ~pat_q : pat_q;
            end
          end
        end else begin
          step_s     = 1'b1;
          wr_phase_d = ~attr_cur_s.has_rd;
          cen_d      = cen_for(sel_q);
          if (attr_cur_s.has_rd) begin
            gwen_d = 1'b1;
            wen_d  = {DW{1'b1}};
          end else begin
            gwen_d = 1'b0;
            wen_d  = {DW{1'b0}};
            d_d    = attr_cur_s.wr_inv ? ~pat_q : pat_q;
          end
        end
      end
      ST_DRAIN: begin
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read pipeline and first-failure capture.
  always_comb begin
    rd1_d       = ~(&cen_q) & gwen_q;
    exp1_d      = attr_cur_s.rd_inv ? ~pat_q : pat_q;
    addr1_d     = addr_s;
    elem1_d     = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_bits_d = fail_bits_q;
    if ((state_q == ST_IDLE) && start) begin
      fail_d      = 1'b0;
      fail_addr_d = {AW{1'b0}};
      fail_elem_d = 3'd0;
      fail_bits_d = {DW{1'b0}};
    end else if (rd1_q && (Q != exp1_q)) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = addr1_q;
        fail_elem_d = elem1_q;
        fail_bits_d = Q ^ exp1_q;
      end else begin
        fail_addr_d = fail_addr_q;
      end
    end else begin
      fail_d = fail_q;
    end
  end

  // State, bus and status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      wr_phase_q  <= 1'b0;
      sel_q       <= 2'd0;
      pat_q       <= {DW{1'b0}};
      last_q      <= {AW{1'b0}};
      cen_q       <= 4'hF;
      gwen_q      <= 1'b1;
      wen_q       <= {DW{1'b1}};
      d_q         <= {DW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd1_q       <= 1'b0;
      exp1_q      <= {DW{1'b0}};
      addr1_q     <= {AW{1'b0}};
      elem1_q     <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= {AW{1'b0}};
      fail_elem_q <= 3'd0;
      fail_bits_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      wr_phase_q  <= wr_phase_d;
      sel_q       <= sel_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      cen_q       <= cen_d;
      gwen_q      <= gwen_d;
      wen_q       <= wen_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd1_q       <= rd1_d;
      exp1_q      <= exp1_d;
      addr1_q     <= addr1_d;
      elem1_q     <= elem1_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_bits_q <= fail_bits_d;
    end
  end

  assign CEN       = cen_q;
  assign GWEN      = gwen_q;
  assign WEN       = wen_q;
  assign A         = addr_s;
  assign D         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: behavioural SRAM with optional
// stuck-at and coupling faults, an access-sequence reference computed from
// the access index, and end-of-run status checks.
module tb_sram_march_bist;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [1:0] sel;
  logic [7:0] pattern;
  logic [7:0] Q = 8'h00;
  logic [3:0] CEN;
  logic       GWEN;
  logic [7:0] WEN;
  logic [9:0] A;
  logic [7:0] D;
  logic       busy, done, fail;
  logic [9:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_bits;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [7:0] mem [0:1023];
  bit         run_active = 1'b0;
  bit         prev_active = 1'b0;
  logic [1:0] cur_sel = 2'd0;
  logic [7:0] cur_pat = 8'h00;
  int         cur_n = 256;
  int         fault_mode = 0;  // 0 none, 1 stuck-at, 2 coupling
  int         acc_k = 0, wr_cnt = 0, rd_cnt = 0, seq_err = 0, cen_err = 0, idle_err = 0;

  sram_march_bist dut (
    .CLK(CLK), .RST(RST), .start(start), .sel(sel), .pattern(pattern), .Q(Q),
    .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bits(fail_bits)
  );

  always #5 CLK = ~CLK;

  function automatic int depth(input logic [1:0] s);
    case (s)
      2'd0:    return 1024;
      2'd1:    return 512;
      default: return 256;
    endcase
  endfunction

  // Expected k-th access of a March C- run over n words.
  function automatic void exp_access(input int k, input int n, input logic [7:0] p,
                                     output bit wr, output int addr, output logic [7:0] data);
    int j, e, r, slot;
    if (k < n) begin
      wr = 1'b1; addr = k; data = p;
    end else if (k < 9 * n) begin
      j = k - n; e = 1 + j / (2 * n); r = j % (2 * n); slot = r / 2;
      wr = (r % 2) == 1;
      addr = (e <= 2) ? slot : (n - 1 - slot);
      data = (e == 1 || e == 3) ? ~p : p;
    end else begin
      wr = 1'b0; addr = n - 1 - (k - 9 * n); data = p;
    end
  endfunction

  // Behavioural SRAM plus bus-sequence observer.
  always @(posedge CLK) begin
    bit         e_wr;
    int         e_addr;
    logic [7:0] e_data;
    logic [7:0] q_v;
    logic [9:0] ea;
    if (RST) begin
      prev_active = 1'b0;
    end else begin
      if (run_active && !prev_active) begin
        acc_k = 0; wr_cnt = 0; rd_cnt = 0; seq_err = 0; cen_err = 0;
      end
      prev_active = run_active;
      if (CEN != 4'hF) begin
        if (!run_active) idle_err++;
        if (CEN != ~(4'b0001 << cur_sel)) cen_err++;
        if (acc_k >= 10 * cur_n) seq_err++;
        exp_access(acc_k, cur_n, cur_pat, e_wr, e_addr, e_data);
        ea = e_addr[9:0];
        if (GWEN !== ~e_wr) seq_err++;
        if (WEN !== (e_wr ? 8'h00 : 8'hFF)) seq_err++;
        if (A !== ea) seq_err++;
        if (e_wr && (D !== e_data)) seq_err++;
        if (!GWEN) begin
          wr_cnt++;
          mem[A] = D;
          if (fault_mode == 1 && A == 10'h005) mem[A][3] = 1'b1;
          if (fault_mode == 2 && A == 10'h010 && acc_k >= 5 * cur_n && acc_k < 7 * cur_n)
            mem[10'h011][0] = ~mem[10'h011][0];
        end else begin
          rd_cnt++;
          q_v = mem[A];
          if (fault_mode == 1 && A == 10'h005) q_v[3] = 1'b1;
          Q <= q_v;
        end
        acc_k++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run; returns cycles from accept edge to done (-1 timeout, -2 reset).
  task automatic run(input logic [1:0] s, input logic [7:0] p, input int pulse_at,
                     input int rst_at, output int done_k, output int busy_k);
    done_k = -1;
    busy_k = 0;
    @(negedge CLK);
    sel = s; pattern = p; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cur_sel = s; cur_pat = p; cur_n = depth(s); run_active = 1'b1;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done_clr", 32'(done), 32'd0);
    check("accept_fail_clr", 32'(fail), 32'd0);
    if (busy) busy_k++;
    for (int k = 1; k <= 12000; k++) begin
      @(posedge CLK); #1;
      if (k == rst_at) begin
        RST = 1'b1;
        #1;
        check("rst_cen", 32'(CEN), 32'hF);
        check("rst_gwen", 32'(GWEN), 32'd1);
        check("rst_wen", 32'(WEN), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        run_active = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        done_k = -2;
        break;
      end
      if (k == pulse_at) begin
        start = 1'b1; sel = ~s; pattern = ~p;
      end else if (k == pulse_at + 1) begin
        start = 1'b0; sel = s; pattern = p;
      end
      if (busy) busy_k++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    run_active = 1'b0;
  endtask

  initial begin
    int dk, bk;
    RST = 1'b1; start = 1'b0; sel = 2'd0; pattern = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_cen", 32'(CEN), 32'hF);
    check("reset_gwen", 32'(GWEN), 32'd1);
    check("reset_wen", 32'(WEN), 32'hFF);
    check("reset_a", 32'(A), 32'd0);
    check("reset_d", 32'(D), 32'd0);
    check("reset_status", {28'd0, busy, done, fail, 1'b0}, 32'd0);
    check("reset_fail_info", {11'd0, fail_addr, fail_elem, fail_bits}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Good memory, sel=2, P=00
    fault_mode = 0;
    run(2'd2, 8'h00, -10, -10, dk, bk);
    check("good_done_cycle", 32'(dk), 32'd2562);
    check("good_busy_cycles", 32'(bk), 32'd2561);
    check("good_fail", 32'(fail), 32'd0);
    check("good_writes", 32'(wr_cnt), 32'd1280);
    check("good_reads", 32'(rd_cnt), 32'd1280);
    check("good_seq", 32'(seq_err), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("done_held", {30'd0, done, busy}, 32'd2);

    // Stuck-at-1 on bit 3 of address 0x05
    fault_mode = 1;
    run(2'd2, 8'h00, -10, -10, dk, bk);
    check("sa_done_cycle", 32'(dk), 32'd2562);
    check("sa_fail", 32'(fail), 32'd1);
    check("sa_fail_addr", 32'(fail_addr), 32'h005);
    check("sa_fail_elem", 32'(fail_elem), 32'd1);
    check("sa_fail_bits", 32'(fail_bits), 32'h08);

    // Full sweep of the 1024-word macro
    fault_mode = 0;
    run(2'd0, 8'h5A, -10, -10, dk, bk);
    check("s0_done_cycle", 32'(dk), 32'd10242);
    check("s0_fail", 32'(fail), 32'd0);
    check("s0_seq", 32'(seq_err), 32'd0);
    check("s0_cen", 32'(cen_err), 32'd0);
    check("s0_accesses", 32'(wr_cnt + rd_cnt), 32'd10240);

    // start/sel/pattern disturbed mid-run
    run(2'd1, 8'hC3, 100, -10, dk, bk);
    check("pulse_done_cycle", 32'(dk), 32'd5122);
    check("pulse_seq", 32'(seq_err), 32'd0);
    check("pulse_cen", 32'(cen_err), 32'd0);
    check("pulse_fail", 32'(fail), 32'd0);

    // Reset mid-run, then a clean run
    run(2'd2, 8'h3C, -10, 300, dk, bk);
    check("abort_flag", 32'(dk), 32'hFFFF_FFFE);
    check("abort_done", 32'(done), 32'd0);
    run(2'd2, 8'h3C, -10, -10, dk, bk);
    check("rerun_done_cycle", 32'(dk), 32'd2562);
    check("rerun_fail", 32'(fail), 32'd0);
    check("rerun_seq", 32'(seq_err), 32'd0);

    // Coupling fault active during M3 only, sel=3
    fault_mode = 2;
    run(2'd3, 8'h0F, -10, -10, dk, bk);
    check("cf_done_cycle", 32'(dk), 32'd2562);
    check("cf_fail", 32'(fail), 32'd1);
    check("cf_fail_elem", 32'(fail_elem), 32'd4);
    check("cf_fail_addr", 32'(fail_addr), 32'h011);
    check("cf_fail_bits", 32'(fail_bits), 32'h01);
    check("cf_cen", 32'(cen_err), 32'd0);

    check("idle_bus_quiet", 32'(idle_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
